// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: access types,
// FSM states, byte-lane constants and alignment helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LB  = 3'd1,
    OP_LBU = 3'd2,
    OP_LH  = 3'd3,
    OP_LHU = 3'd4,
    OP_SW  = 3'd5,
    OP_SB  = 3'd6,
    OP_SH  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  function automatic logic is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
  endfunction

  // Word accesses need a 4-byte boundary, halfwords a 2-byte boundary.
  function automatic logic is_aligned(input op_e op, input logic [1:0] lo);
    logic ok;
    case (op)
      OP_LW, OP_SW:         ok = (lo == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = ~lo[0];
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and data replication, plus
// load lane extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] lane_shifted;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  s;
    logic signed [31:0] r;
    s = b;
    r = s;
    return sgn ? r : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] s;
    logic signed [31:0] r;
    s = h;
    r = s;
    return sgn ? r : {16'd0, h};
  endfunction

  // Addressed lane moved down to bit 0 so extraction is lane-independent.
  assign lane_shifted = mem_rdata >> {lo, 3'b000};

  // Per-op lane selection for both directions.
  always_comb begin
    be        = BE_WORD;
    wdata_rep = wdata;
    load_data = '0;
    case (op)
      OP_SB: begin
        be        = BE_BYTE0 << lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be        = lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_rep = {2{wdata[15:0]}};
      end
      OP_LB:   load_data = ext8(lane_shifted[7:0], 1'b1);
      OP_LBU:  load_data = ext8(lane_shifted[7:0], 1'b0);
      OP_LH:   load_data = ext16(lane_shifted[15:0], 1'b1);
      OP_LHU:  load_data = ext16(lane_shifted[15:0], 1'b0);
      OP_LW:   load_data = mem_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: runs one req/ack data-memory transaction per
// start, with a timeout, and returns extended load data or an error.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TCNT_W         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [TCNT_W-1:0] TC_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state;
  logic [TCNT_W-1:0] tcnt;
  op_e               op_in;
  op_e               op_q;
  logic [1:0]        lo_q;
  op_e               sel_op;
  logic [1:0]        sel_lo;
  logic              aligned;
  logic [3:0]        be_c;
  logic [31:0]       wrep_c;
  logic [31:0]       load_c;

  assign op_in   = op_e'(op);
  assign aligned = is_aligned(op_in, addr[1:0]);

  // In IDLE the lane logic sees the incoming request (to build the bus
  // fields); afterwards it sees the latched op/offset (to extract loads).
  assign sel_op = (state == ST_IDLE) ? op_in : op_q;
  assign sel_lo = (state == ST_IDLE) ? addr[1:0] : lo_q;

  lsu_lane_align u_lane (
    .op        (sel_op),
    .lo        (sel_lo),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .be        (be_c),
    .wdata_rep (wrep_c),
    .load_data (load_c)
  );

  // Latch the access type and byte offset at launch for load extraction.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      op_q <= op_in;
      lo_q <= addr[1:0];
    end
  end

  // Transaction FSM with timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          addr_err <= 1'b0;
          bus_err  <= 1'b0;
          tcnt     <= '0;
          if (start) begin
            busy <= 1'b1;
            if (aligned) begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store(op_in);
              mem_be    <= be_c;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wrep_c;
            end else begin
              state    <= ST_RESP;
              done     <= 1'b1;
              addr_err <= 1'b1;
              rdata    <= '0;
            end
          end
        end
        ST_REQ: begin
          // An ack on the final timeout cycle still completes normally.
          if (mem_ack || tcnt == TC_LAST) begin
            state     <= ST_RESP;
            done      <= 1'b1;
            bus_err   <= ~mem_ack;
            rdata     <= mem_ack ? load_c : '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_RESP: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          addr_err <= 1'b0;
          bus_err  <= 1'b0;
          tcnt     <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed vector table, hand-written corner
// sequences, and randomized transactions against a behavioural model.
module tb_lsu_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO), .TCNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    int          req_cnt;
    logic [3:0]  be;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rd;
    logic        aerr;
    logic        berr;
    logic        stable;
    logic        busy_done;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          dly;
    logic [3:0]  ebe;
    logic        ewe;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        eaerr;
    int          edone;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: access size and offset arithmetic straight from the rules.
  function automatic res_t model(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] mrd,
                                 input int dly);
    res_t        e;
    int          k;
    int          size;
    bit          sgn;
    logic [31:0] mask;
    logic [31:0] v;
    k    = int'(a % 4);
    size = (o == 3'd0 || o == 3'd5) ? 4 :
           (o == 3'd1 || o == 3'd2 || o == 3'd6) ? 1 : 2;
    sgn  = (o == 3'd1 || o == 3'd3);
    e.aerr      = (k % size) != 0;
    e.we        = (o >= 3'd5);
    e.maddr     = a - 32'(k);
    e.be        = e.we ? 4'(((1 << size) - 1) << k) : 4'hF;
    e.mwd       = '0;
    for (int i = 0; i < 4; i++) e.mwd[8*i +: 8] = wd[8*(i % size) +: 8];
    e.stable    = 1'b1;
    e.busy_done = 1'b1;
    if (e.aerr) begin
      e.req_cnt  = 0;
      e.berr     = 1'b0;
      e.rd       = '0;
      e.done_cyc = 1;
    end else begin
      e.berr     = (dly < 1 || dly > TO);
      e.req_cnt  = e.berr ? TO : dly;
      e.done_cyc = e.req_cnt + 1;
      if (e.we || e.berr) e.rd = '0;
      else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
        v    = (mrd >> (8 * k)) & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        e.rd = v;
      end
    end
    return e;
  endfunction

  // Launch one transaction, act as memory (ack after dly REQ cycles, 0 = never),
  // optionally poke start while busy, then check the idle cycles after done.
  task automatic run_txn(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mrd,
                         input int dly, input int restart_at, output res_t r);
    int   cyc;
    int   req_cnt;
    bit   got;
    r.done_cyc = -1; r.req_cnt = 0; r.be = '0; r.we = 1'b0; r.maddr = '0;
    r.mwd = '0; r.rd = '0; r.aerr = 1'b0; r.berr = 1'b0; r.stable = 1'b1;
    r.busy_done = 1'b0;
    @(negedge clk);
    op = o; addr = a; wdata = wd; start = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 1; req_cnt = 0; got = 1'b0;
    while (!got && cyc <= 40) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          r.be = mem_be; r.we = mem_we; r.maddr = mem_addr; r.mwd = mem_wdata;
        end else if ({mem_be, mem_we, mem_addr, mem_wdata} !== {r.be, r.we, r.maddr, r.mwd})
          r.stable = 1'b0;
        if (busy !== 1'b1) r.stable = 1'b0;
        if (req_cnt == dly) begin
          mem_ack = 1'b1; mem_rdata = mrd;
        end
      end
      if (done) begin
        got = 1'b1; r.done_cyc = cyc; r.rd = rdata; r.aerr = addr_err;
        r.berr = bus_err; r.busy_done = busy;
      end
      if (cyc == restart_at) begin
        start = 1'b1; op = 3'd5; addr = $urandom & 32'hFFFF_FFFC;
      end else start = 1'b0;
      if (!got) begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0; start = 1'b0;
    r.req_cnt = req_cnt;
    @(negedge clk);
    chk({nm, "_post_flags"}, {28'd0, done, busy, addr_err, bus_err}, 32'd0);
    chk({nm, "_post_hold"}, rdata, r.rd);
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({nm, "_stray_ack"}, {29'd0, mem_req, busy, done}, 32'd0);
  endtask

  task automatic cmp(input string nm, input res_t r, input res_t e);
    chk({nm, "_done_cyc"}, r.done_cyc, e.done_cyc);
    chk({nm, "_req_cycles"}, r.req_cnt, e.req_cnt);
    chk({nm, "_addr_err"}, {31'd0, r.aerr}, {31'd0, e.aerr});
    chk({nm, "_bus_err"}, {31'd0, r.berr}, {31'd0, e.berr});
    chk({nm, "_rdata"}, r.rd, e.rd);
    chk({nm, "_req_stable"}, {31'd0, r.stable}, 32'd1);
    chk({nm, "_busy_at_done"}, {31'd0, r.busy_done}, 32'd1);
    if (e.req_cnt > 0) begin
      chk({nm, "_mem_be"}, {28'd0, r.be}, {28'd0, e.be});
      chk({nm, "_mem_we"}, {31'd0, r.we}, {31'd0, e.we});
      chk({nm, "_mem_addr"}, r.maddr, e.maddr);
      if (e.we) chk({nm, "_mem_wdata"}, r.mwd, e.mwd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    res_t r;
    res_t e;
    logic [2:0] ro;
    logic [31:0] ra, rw, rm;
    int rd;

    vecs[0]  = '{3'd0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 4'hF, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[1]  = '{3'd1, 32'h103, 32'h0,        32'h80FF0000, 1, 4'hF, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    vecs[2]  = '{3'd2, 32'h103, 32'h0,        32'h80FF0000, 1, 4'hF, 1'b0, 32'h0,        32'h00000080, 1'b0, 2};
    vecs[3]  = '{3'd7, 32'h206, 32'h1234ABCD, 32'h0,        2, 4'hC, 1'b1, 32'hABCDABCD, 32'h0,        1'b0, 3};
    vecs[4]  = '{3'd0, 32'h102, 32'h0,        32'h0,        1, 4'h0, 1'b0, 32'h0,        32'h0,        1'b1, 1};
    vecs[5]  = '{3'd3, 32'h101, 32'h0,        32'h0,        1, 4'h0, 1'b0, 32'h0,        32'h0,        1'b1, 1};
    vecs[6]  = '{3'd3, 32'h102, 32'h0,        32'h80017FFF, 3, 4'hF, 1'b0, 32'h0,        32'hFFFF8001, 1'b0, 4};
    vecs[7]  = '{3'd4, 32'h100, 32'h0,        32'h8001F00D, 1, 4'hF, 1'b0, 32'h0,        32'h0000F00D, 1'b0, 2};
    vecs[8]  = '{3'd6, 32'h301, 32'h000000A5, 32'h0,        1, 4'h2, 1'b1, 32'hA5A5A5A5, 32'h0,        1'b0, 2};
    vecs[9]  = '{3'd5, 32'h400, 32'hCAFEF00D, 32'h0,        2, 4'hF, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 3};
    vecs[10] = '{3'd5, 32'h402, 32'hCAFEF00D, 32'h0,        1, 4'h0, 1'b0, 32'h0,        32'h0,        1'b1, 1};
    vecs[11] = '{3'd6, 32'h303, 32'h12345678, 32'h0,        4, 4'h8, 1'b1, 32'h78787878, 32'h0,        1'b0, 5};

    rst = 1'b1; start = 1'b0; op = '0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {24'd0, busy, done, addr_err, bus_err, mem_req, mem_we, 2'b00},
        32'd0);
    chk("reset_be", {28'd0, mem_be}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
              vecs[i].mrd, vecs[i].dly, -1, r);
      e.done_cyc  = vecs[i].edone;
      e.req_cnt   = vecs[i].eaerr ? 0 : vecs[i].dly;
      e.aerr      = vecs[i].eaerr;
      e.berr      = 1'b0;
      e.rd        = vecs[i].erd;
      e.be        = vecs[i].ebe;
      e.we        = vecs[i].ewe;
      e.maddr     = vecs[i].addr & 32'hFFFF_FFFC;
      e.mwd       = vecs[i].ewd;
      e.stable    = 1'b1;
      e.busy_done = 1'b1;
      cmp($sformatf("vec%0d", i), r, e);
    end

    // Timeout with a second start attempted while busy.
    run_txn("timeout", 3'd0, 32'h600, 32'h0, 32'h0, 0, 5, r);
    e.done_cyc = TO + 1; e.req_cnt = TO; e.aerr = 1'b0; e.berr = 1'b1; e.rd = '0;
    e.be = 4'hF; e.we = 1'b0; e.maddr = 32'h600; e.mwd = '0; e.stable = 1'b1;
    e.busy_done = 1'b1;
    cmp("timeout", r, e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_second_txn%0d", i), {30'd0, mem_req, busy}, 32'd0);
    end

    // Ack on the very cycle the timeout would fire.
    run_txn("ack_at_limit", 3'd0, 32'h604, 32'h0, 32'h11223344, TO, -1, r);
    e.done_cyc = TO + 1; e.req_cnt = TO; e.berr = 1'b0; e.rd = 32'h11223344;
    e.maddr = 32'h604;
    cmp("ack_at_limit", r, e);

    // Reset pulse in the middle of REQ.
    @(negedge clk);
    op = 3'd0; addr = 32'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midreq_req_high", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midreq_rst_drop", {29'd0, mem_req, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("after_rst%0d", i), {29'd0, mem_req, busy, done}, 32'd0);
    end
    run_txn("after_rst_txn", 3'd2, 32'h701, 32'h0, 32'h0000FE00, 2, -1, r);
    cmp("after_rst_txn", r, model(3'd2, 32'h701, 32'h0, 32'h0000FE00, 2));

    // Randomized transactions against the behavioural model.
    for (int n = 0; n < 150; n++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rw = $urandom;
      rm = $urandom;
      rd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      run_txn($sformatf("rnd%0d", n), ro, ra, rw, rm, rd, -1, r);
      cmp($sformatf("rnd%0d", n), r, model(ro, ra, rw, rm, rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
